// File: rtl/proc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// proc_sequencer_pkg
// Shared definitions for the instruction sequencer of the 9-bit
// MV/MVI/ADD/SUB processor (word format iiixxxyyy).
//   WORD_W   : width of a program word / processor DIN
//   TMR_W    : width of the shared setup/watchdog down-counter
//   OP_*     : opcode values found in word[8:6]
//   state_t  : sequencer state encoding
//   is_reserved() : true for the unused opcodes 100..110, which are skipped
// -----------------------------------------------------------------------------
package proc_sequencer_pkg;

    localparam int WORD_W = 9;
    localparam int TMR_W  = 8;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_FETCH_IMM,
        ST_LOAD_IMM,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_HALT
    } state_t;

    // Opcodes 100..110 carry no meaning for the processor and are treated as NOPs.
    function automatic logic is_reserved(input logic [2:0] op);
        return op[2] && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/proc_sequencer_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable down-counter shared by the sequencer for the DIN setup hold and the
// Done-handshake watchdog. The two uses never overlap in time.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (count cleared)
//   i_load     : load i_load_val on the next edge (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one per cycle, stopping at zero
//   o_zero     : current count is zero
// -----------------------------------------------------------------------------
module seq_timer
    import proc_sequencer_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/proc_sequencer.sv
// -----------------------------------------------------------------------------
// proc_sequencer
// Autonomous fetch/issue engine for the 9-bit four-instruction processor.
// Reads words from a synchronous program memory, holds each instruction on
// the processor's DIN for SETUP_CYC cycles, pulses Run for one cycle, then
// follows the Done handshake (low, then high) before fetching the next word.
//   i_clk, i_rst_n       : clock / asynchronous active-low reset
//   i_start, i_start_addr: begin execution at i_start_addr (sampled in IDLE/HALT)
//   i_stop               : return to IDLE at the next instruction boundary
//   o_mem_addr, o_mem_rd : program memory request; i_mem_data valid 1 cycle later
//   i_mem_data           : program word
//   o_proc_din, o_proc_run, i_proc_done : processor interface
//   o_busy, o_halted, o_err_timeout     : status (halted/err_timeout sticky)
//   o_pc, o_instr_count  : program counter and saturating issue count
// -----------------------------------------------------------------------------
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int AW        = 6,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [AW-1:0]     i_start_addr,
    input  logic              i_stop,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_rd,
    input  logic [WORD_W-1:0] i_mem_data,
    output logic [WORD_W-1:0] o_proc_din,
    output logic              o_proc_run,
    input  logic              i_proc_done,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_err_timeout,
    output logic [AW-1:0]     o_pc,
    output logic [15:0]       o_instr_count
);

    state_t              r_state;
    logic [AW-1:0]       r_pc;
    logic [WORD_W-1:0]   r_instr;
    logic [WORD_W-1:0]   r_imm;
    logic [AW-1:0]       r_mem_addr;
    logic                r_mem_rd;
    logic [WORD_W-1:0]   r_proc_din;
    logic                r_proc_run;
    logic                r_busy;
    logic                r_halted;
    logic                r_err_timeout;
    logic [15:0]         r_instr_count;

    logic [2:0]          w_op_mem;
    logic                w_op_one_word;
    logic                w_is_mvi;
    logic [AW-1:0]       w_pc_inc;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_zero;

    assign w_op_mem      = i_mem_data[8:6];
    assign w_op_one_word = (w_op_mem == OP_MV) || (w_op_mem == OP_ADD) || (w_op_mem == OP_SUB);
    assign w_is_mvi      = (r_instr[8:6] == OP_MVI);
    assign w_pc_inc      = r_pc + AW'(1);

    // The timer is loaded on the edge that enters SETUP (hold length) or a
    // wait state (watchdog), so each state starts with a fresh count.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TMR_W'(TIMEOUT - 1);
        w_tmr_en   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_op_one_word) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(SETUP_CYC - 1);
                end
            end
            ST_LOAD_IMM: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_W'(SETUP_CYC - 1);
            end
            ST_SETUP:   w_tmr_en = 1'b1;
            ST_ISSUE:   w_tmr_load = 1'b1;
            ST_WAIT_LO: begin
                if (!i_proc_done) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_WAIT_HI: w_tmr_en = 1'b1;
            default: ;
        endcase
    end

    seq_timer #(.W(TMR_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    // All processor- and memory-facing outputs are set on the edge that enters
    // the state they belong to, so they are stable for that whole state.
    // mem_rd and proc_run default low, which makes them single-cycle strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_imm         <= '0;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_proc_din    <= '0;
            r_proc_run    <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_err_timeout <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_mem_rd   <= 1'b0;
            r_proc_run <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (i_start) begin
                        r_pc          <= i_start_addr;
                        r_mem_addr    <= i_start_addr;
                        r_mem_rd      <= 1'b1;
                        r_halted      <= 1'b0;
                        r_err_timeout <= 1'b0;
                        r_instr_count <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_instr <= i_mem_data;
                    r_pc    <= w_pc_inc;
                    if (w_op_mem == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_HALT;
                    end else if (is_reserved(w_op_mem)) begin
                        if (i_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_mem_addr <= w_pc_inc;
                            r_mem_rd   <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end else if (w_op_mem == OP_MVI) begin
                        // The immediate lives at the next address, wrapping past the top.
                        r_mem_addr <= w_pc_inc;
                        r_mem_rd   <= 1'b1;
                        r_state    <= ST_FETCH_IMM;
                    end else begin
                        r_proc_din <= i_mem_data;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_FETCH_IMM: r_state <= ST_LOAD_IMM;
                ST_LOAD_IMM: begin
                    r_imm      <= i_mem_data;
                    r_pc       <= w_pc_inc;
                    r_proc_din <= r_instr;
                    r_state    <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (w_tmr_zero) begin
                        r_proc_run <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_instr_count != 16'hFFFF) begin
                        r_instr_count <= r_instr_count + 16'd1;
                    end
                    // MVI's second word is what the processor reads while it executes.
                    r_proc_din <= w_is_mvi ? r_imm : r_instr;
                    r_state    <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!i_proc_done) begin
                        r_state <= ST_WAIT_HI;
                    end else if (w_tmr_zero) begin
                        r_err_timeout <= 1'b1;
                        r_halted      <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_HALT;
                    end
                end
                ST_WAIT_HI: begin
                    if (i_proc_done) begin
                        if (i_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_mem_addr <= r_pc;
                            r_mem_rd   <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end else if (w_tmr_zero) begin
                        r_err_timeout <= 1'b1;
                        r_halted      <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_HALT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_mem_rd      = r_mem_rd;
    assign o_proc_din    = r_proc_din;
    assign o_proc_run    = r_proc_run;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_err_timeout = r_err_timeout;
    assign o_pc          = r_pc;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_proc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proc_sequencer
// Scoreboard bench: a reference model walks each program and queues the
// instructions that must be issued; a processor model answers the Run/Done
// handshake and a monitor compares each observed issue with the queue.
// -----------------------------------------------------------------------------
module tb_proc_sequencer;
    import proc_sequencer_pkg::*;

    localparam int AW        = 6;
    localparam int DEPTH     = 64;
    localparam int SETUP_CYC = 2;
    localparam int TIMEOUT   = 15;

    typedef struct {
        logic [8:0]    instr;
        logic [8:0]    second;
        logic [AW-1:0] pc;
    } issue_t;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] startAddrIn = '0;
    logic          stop = 1'b0;
    logic [AW-1:0] memAddr;
    logic          memRd;
    logic [8:0]    memData = '0;
    logic [8:0]    procDin;
    logic          procRun;
    logic          procDone;
    logic          busy;
    logic          halted;
    logic          errTimeout;
    logic [AW-1:0] pc;
    logic [15:0]   instrCount;

    logic [8:0]    prog [DEPTH];
    issue_t        expQ [$];
    int            assertCount = 0;
    int            failCount = 0;
    int            runPulses = 0;
    bit            stuckMode = 1'b0;

    proc_sequencer #(.AW(AW), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_start       (start),
        .i_start_addr  (startAddrIn),
        .i_stop        (stop),
        .o_mem_addr    (memAddr),
        .o_mem_rd      (memRd),
        .i_mem_data    (memData),
        .o_proc_din    (procDin),
        .o_proc_run    (procRun),
        .i_proc_done   (procDone),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_err_timeout (errTimeout),
        .o_pc          (pc),
        .o_instr_count (instrCount)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: a read strobe returns the word one cycle later.
    always @(posedge clk) begin
        if (memRd) memData <= prog[memAddr];
    end

    // Processor model: Run drops Done, which returns high after a random
    // 1..4 cycles (never, in stuck mode). The word on DIN during Run and the
    // word one cycle later are captured as one observed issue.
    int            doneDelay;
    bit            captureNext;
    bit            obsValid;
    logic [8:0]    obsInstr;
    logic [8:0]    obsSecond;
    logic [AW-1:0] obsPc;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            procDone    <= 1'b1;
            doneDelay   <= 0;
            captureNext <= 1'b0;
            obsValid    <= 1'b0;
        end else begin
            obsValid <= 1'b0;
            if (captureNext) begin
                obsSecond   <= procDin;
                obsPc       <= pc;
                obsValid    <= 1'b1;
                captureNext <= 1'b0;
            end
            if (procRun) begin
                procDone    <= 1'b0;
                doneDelay   <= stuckMode ? 0 : int'($urandom_range(1, 4));
                obsInstr    <= procDin;
                captureNext <= 1'b1;
            end else if (doneDelay > 0) begin
                if (doneDelay == 1) procDone <= 1'b1;
                doneDelay <= doneDelay - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every observed issue, and checks that
    // each Run pulse is one cycle wide and preceded by a stable-DIN hold.
    issue_t     monExp;
    int         stableCnt = 0;
    logic       prevRun = 1'b0;
    logic [8:0] prevDin = '0;

    always @(negedge clk) begin
        if (rstN) begin
            if (obsValid) begin
                checkOutput("issue_expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    monExp = expQ.pop_front();
                    checkOutput("issue_instr", obsInstr, monExp.instr);
                    checkOutput("issue_second", obsSecond, monExp.second);
                    checkOutput("issue_pc", obsPc, monExp.pc);
                end
            end
            if (procRun) begin
                runPulses++;
                checkOutput("run_single_cycle", prevRun, 0);
                checkOutput("setup_hold", stableCnt >= SETUP_CYC, 1);
                checkOutput("setup_din_stable", procDin, prevDin);
                stableCnt = 0;
            end else if (procDin == prevDin) begin
                stableCnt++;
            end else begin
                stableCnt = 1;
            end
            prevRun = procRun;
            prevDin = procDin;
        end else begin
            stableCnt = 0;
            prevRun   = 1'b0;
        end
    end

    // Reference model: walks the program by the instruction-set rules.
    task automatic runModel(input logic [AW-1:0] startAddr, input bit doPush,
                            output bit halts, output logic [AW-1:0] finalPc, output int cnt);
        int         pcM;
        logic [8:0] w;
        issue_t     it;
        pcM   = int'(startAddr);
        halts = 1'b0;
        cnt   = 0;
        for (int step = 0; step < 300; step++) begin
            w   = prog[pcM];
            pcM = (pcM + 1) % DEPTH;
            if (w[8:6] == 3'b111) begin
                halts = 1'b1;
                break;
            end
            if (w[8:6] < 3'b100) begin
                it.instr  = w;
                it.second = w;
                if (w[8:6] == 3'b001) begin
                    it.second = prog[pcM];
                    pcM = (pcM + 1) % DEPTH;
                end
                it.pc = AW'(pcM);
                if (doPush) expQ.push_back(it);
                cnt++;
            end
        end
        finalPc = AW'(pcM);
    endtask

    task automatic fillProg(input logic [8:0] w);
        for (int a = 0; a < DEPTH; a++) prog[a] = w;
    endtask

    task automatic genProgram();
        int         r;
        logic [8:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            r = int'($urandom_range(0, 19));
            w = 9'($urandom);
            if (r < 10)      w[8:6] = (r < 4) ? 3'b000 : ((r < 7) ? 3'b010 : 3'b011);
            else if (r < 14) w[8:6] = 3'b001;
            else if (r < 17) w[8:6] = 3'($urandom_range(4, 6));
            else             w[8:6] = 3'b111;
            prog[a] = w;
        end
    endtask

    task automatic pulseStart(input logic [AW-1:0] addr);
        @(negedge clk);
        startAddrIn = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < 5000);
        checkOutput({name, "_finished"}, busy, 0);
    endtask

    task automatic waitRun(input string name);
        int cyc = 0;
        while (!procRun && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_run_seen"}, procRun, 1);
    endtask

    // Runs the loaded program from startAddr and checks the end state against the model.
    task automatic applyStimulus(input logic [AW-1:0] startAddr, input string name);
        bit            halts;
        logic [AW-1:0] expPc;
        int            expCnt;
        runModel(startAddr, 1'b1, halts, expPc, expCnt);
        pulseStart(startAddr);
        waitIdle(name);
        repeat (2) @(negedge clk);
        checkOutput({name, "_halted"}, halted, 1);
        checkOutput({name, "_err"}, errTimeout, 0);
        checkOutput({name, "_pc"}, pc, expPc);
        checkOutput({name, "_count"}, instrCount, expCnt);
        checkOutput({name, "_queue_drained"}, expQ.size(), 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_mem_addr"}, memAddr, 0);
        checkOutput({name, "_mem_rd"}, memRd, 0);
        checkOutput({name, "_din"}, procDin, 0);
        checkOutput({name, "_run"}, procRun, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_halted"}, halted, 0);
        checkOutput({name, "_err"}, errTimeout, 0);
        checkOutput({name, "_pc"}, pc, 0);
        checkOutput({name, "_count"}, instrCount, 0);
    endtask

    // Directed scenarios first, then random programs, then stop/reset/timeout.
    int            pulsesBefore;
    int            cyc;
    bit            rdSeen;
    bit            rHalts;
    logic [AW-1:0] rStart;
    logic [AW-1:0] rPc;
    int            rCnt;
    issue_t        item;

    initial begin
        fillProg(9'o700);
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        prog[0] = 9'o100; prog[1] = 9'o005; prog[2] = 9'o700;
        applyStimulus(0, "mvi_halt");
        checkOutput("mvi_halt_pc_const", pc, 3);
        checkOutput("mvi_halt_count_const", instrCount, 1);

        fillProg(9'o700);
        prog[0] = 9'o010; prog[1] = 9'o210; prog[2] = 9'o310;
        pulsesBefore = runPulses;
        applyStimulus(0, "mv_add_sub");
        checkOutput("mv_add_sub_pulses", runPulses - pulsesBefore, 3);

        fillProg(9'o700);
        prog[63] = 9'o100; prog[0] = 9'h0AA; prog[1] = 9'o700;
        applyStimulus(63, "pc_wrap");

        fillProg(9'o700);
        prog[0] = 9'o400;
        pulsesBefore = runPulses;
        applyStimulus(0, "reserved");
        checkOutput("reserved_pulses", runPulses - pulsesBefore, 0);

        for (int t = 0; t < 6; t++) begin
            do begin
                genProgram();
                rStart = AW'($urandom);
                runModel(rStart, 1'b0, rHalts, rPc, rCnt);
            end while (!rHalts || rCnt > 60);
            applyStimulus(rStart, "random");
        end

        // stop raised during WAIT_LO: the handshake completes, then IDLE.
        for (int a = 0; a < DEPTH; a++) prog[a] = {3'b000, 6'($urandom)};
        item.instr = prog[0]; item.second = prog[0]; item.pc = 1;
        expQ.push_back(item);
        pulseStart(0);
        waitRun("stop");
        @(posedge clk);
        #1 stop = 1'b1;
        waitIdle("stop");
        repeat (2) @(negedge clk);
        checkOutput("stop_halted", halted, 0);
        checkOutput("stop_count", instrCount, 1);
        checkOutput("stop_pc", pc, 1);
        checkOutput("stop_done_high", procDone, 1);
        checkOutput("stop_queue_drained", expQ.size(), 0);
        stop = 1'b0;

        // Reset in the middle of SETUP aborts before any Run pulse.
        fillProg(9'o700);
        prog[0] = 9'o210;
        pulsesBefore = runPulses;
        pulseStart(0);
        @(posedge clk);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1 checkAllZero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_run_low", procRun, 0);
        end
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midreset_pulses", runPulses - pulsesBefore, 0);

        // Done stuck low after ISSUE: watchdog halts with err_timeout.
        fillProg(9'o700);
        prog[0] = 9'o010;
        stuckMode = 1'b1;
        item.instr = 9'o010; item.second = 9'o010; item.pc = 1;
        expQ.push_back(item);
        pulseStart(0);
        waitRun("timeout");
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!errTimeout && cyc < 100);
        checkOutput("timeout_latency", (cyc >= TIMEOUT) && (cyc <= TIMEOUT + 2), 1);
        checkOutput("timeout_err", errTimeout, 1);
        checkOutput("timeout_halted", halted, 1);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_count", instrCount, 1);
        checkOutput("timeout_pc", pc, 1);
        rdSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (memRd) rdSeen = 1'b1;
        end
        checkOutput("timeout_no_fetch", rdSeen, 0);
        checkOutput("timeout_queue_drained", expQ.size(), 0);
        stuckMode = 1'b0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Autonomous instruction sequencer for the 9-bit four-instruction processor (MV/MVI/ADD/SUB, word format iiixxxyyy).
- Fetches words from a synchronous program memory, presents them on the processor's DIN, and pulses Run.
- Waits for the processor's Done handshake, then advances the program counter.
- Sits between program ROM/RAM and the processor; replaces manual DIN/Run driving from switches.

Parameters:
AW, 6, program memory address width; PC wraps modulo 2^AW
SETUP_CYC, 2, cycles proc_din is held with proc_run low before issue (IR capture window); legal 1..7
TIMEOUT, 15, max cycles spent waiting in either Done phase before error; legal 2..255

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE; begins execution at start_addr
start_addr  in  AW  initial PC, sampled with start
stop  in  1  level; finish current instruction, then return to IDLE
mem_addr  out  AW  program memory address (registered)
mem_rd  out  1  read strobe; mem_data valid exactly 1 cycle later
mem_data  in  9  program word
proc_din  out  9  processor DIN (registered)
proc_run  out  1  processor Run (registered)
proc_done  in  1  processor Done
busy  out  1  high in every state except IDLE and HALT
halted  out  1  sticky; set on HALT opcode or timeout
err_timeout  out  1  sticky; set on handshake timeout
pc  out  AW  current program counter
instr_count  out  16  instructions issued since start; saturates at 16'hFFFF

Behaviour:
- Reset (async, Resetn=0): state=IDLE; all outputs 0; internal counters 0. Reset mid-instruction aborts immediately with no further proc_run.
- Opcode decode on word[8:6]:
  - 000 MV, 010 ADD, 011 SUB: one-word instructions.
  - 001 MVI: two words; the second word is the immediate.
  - 111 HALT.
  - 100..110: reserved, skipped as NOP (no issue, PC advances, count unchanged).
- States:
  - IDLE: proc_run=0. start=1 -> pc<=start_addr, clear halted, err_timeout, instr_count; go FETCH.
  - FETCH: mem_addr<=pc, mem_rd=1 for 1 cycle -> LOAD.
  - LOAD: instr<=mem_data; pc<=pc+1. Then by opcode:
    - HALT -> HALT.
    - reserved -> FETCH.
    - MVI -> FETCH_IMM.
    - otherwise -> SETUP.
  - FETCH_IMM: mem_addr<=pc, mem_rd=1 -> LOAD_IMM.
  - LOAD_IMM: imm<=mem_data; pc<=pc+1 -> SETUP. The immediate word is never decoded.
  - SETUP: proc_din=instr, proc_run=0 for SETUP_CYC cycles -> ISSUE.
  - ISSUE: proc_run=1 for exactly 1 cycle; proc_din=instr; instr_count++ -> WAIT_LO.
  - WAIT_LO: proc_run=0; proc_din=imm if MVI, else instr. Wait for proc_done=0 -> WAIT_HI.
  - WAIT_HI: same proc_din as WAIT_LO. On proc_done=1: stop=1 -> IDLE, else -> FETCH.
  - HALT: halted=1, busy=0, outputs frozen; leaves only via reset, or via start=1 (handled as from IDLE).
- Timeout: a counter runs in WAIT_LO/WAIT_HI and clears on each state entry. Reaching TIMEOUT -> err_timeout=1, halted=1, HALT.
- PC wrap: pc=2^AW-1 increments to 0. An MVI at the last address takes its immediate from address 0.
- stop is checked only at WAIT_HI exit and in LOAD for reserved/NOP words. stop never cuts a handshake.
- start is ignored while busy.
- proc_din/proc_run change only on Clock edges (glitch-free into the processor).
- Latency per instruction: 1-word = 2 + SETUP_CYC + 1 + handshake cycles; MVI adds 2.

Decomposition:
- Shared package: opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_HALT=3'b111; state encoding enum (4 bits); word width 9.
- One sub-module, seq_timer: loadable down-counter used for both the SETUP_CYC hold and the TIMEOUT watchdog (load, en, zero outputs).

Test Plan:
- Program @0: MVI R0,#5 (9'o100, 9'o005); HALT (9'o700); processor model. start_addr=0 -> MVI issues with proc_din=9'o100 at ISSUE, then 9'o005 in WAIT. halted=1, pc=3, instr_count=1.
- Program MV R1,R0; ADD R1,R0; SUB R1,R0; HALT -> exactly 3 single-cycle proc_run pulses. Each pulse is preceded by exactly SETUP_CYC=2 cycles of run low with stable din.
- Processor model holds proc_done=0 forever after ISSUE -> after 15 cycles err_timeout=1, halted=1; no further mem_rd.
- start_addr=63 (AW=6), word@63=MVI, word@0=imm 9'h0AA -> imm fetched from address 0; pc=1 after LOAD_IMM.
- Reserved opcode 9'o400 at addr 0, HALT at 1 -> no proc_run pulse; instr_count=0; halted=1.
- stop raised during WAIT_LO -> instruction completes, IDLE entered after proc_done rises. Resetn pulsed low mid-SETUP -> proc_run stays 0 and all outputs are 0 asynchronously.
